// File: rtl/word_sequencer.sv
// Streams the current level's word from a run-time programmable scancode table
// to a comparator, one character per valid/ready transfer, and tracks level progress.
module word_sequencer #(
  parameter int NUM_WORDS = 4,
  parameter int MAX_CHARS = 11,
  parameter int CHAR_W    = 8,
  parameter bit WRAP      = 1'b1,
  parameter int WIDX_W    = $clog2(NUM_WORDS),
  parameter int CIDX_W    = $clog2(MAX_CHARS),
  parameter int LEN_W     = $clog2(MAX_CHARS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic              cfg_len_we,
  input  logic [WIDX_W-1:0] cfg_word,
  input  logic [CIDX_W-1:0] cfg_char,
  input  logic [CHAR_W-1:0] cfg_data,
  input  logic              start,
  input  logic              next_level,
  input  logic              char_ready,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_data,
  output logic [CIDX_W-1:0] char_idx,
  output logic [LEN_W-1:0]  num_char,
  output logic [WIDX_W-1:0] level,
  output logic              word_done,
  output logic              game_done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDX_W-1:0]   level_q, level_d;
  logic                valid_q, valid_d;
  logic [CHAR_W-1:0]   data_q, data_d;
  logic [CIDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]    num_q, num_d;
  logic                wd_q, wd_d;
  logic                gd_q, gd_d;

  logic [CHAR_W-1:0]   tbl_q [NUM_WORDS][MAX_CHARS];
  logic [LEN_W-1:0]    len_q [NUM_WORDS];

  logic                cfg_ok;
  logic                adv;
  logic [LEN_W-1:0]    cur_len;
  logic                last_char;

  // The table is writable only while nothing is being streamed from it.
  assign cfg_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                  (int'(cfg_word) < NUM_WORDS);

  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      if (cfg_we && (int'(cfg_char) < MAX_CHARS))
        tbl_q[cfg_word][cfg_char] <= cfg_data;
      if (cfg_len_we)
        len_q[cfg_word] <= cfg_data[LEN_W-1:0];
    end
  end

  assign cur_len   = len_q[level_q];
  assign last_char = (LEN_W'(idx_q) == (num_q - LEN_W'(1)));

  // Handshake: a character transfers on a rising edge where char_valid and
  // char_ready are both high; while valid is high and ready low, data/idx hold.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    num_d   = num_q;
    wd_d    = 1'b0;
    gd_d    = gd_q;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (next_level)  adv = 1'b1;
        else if (start)  state_d = S_LOAD;
      end
      S_LOAD: begin
        if (next_level) begin
          adv     = 1'b1;
          state_d = S_IDLE;
        end else begin
          num_d = (cur_len > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : cur_len;
          idx_d = '0;
          if (cur_len == '0) begin
            wd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            valid_d = 1'b1;
            data_d  = tbl_q[level_q][0];
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        // An abort takes priority over a transfer in the same cycle.
        if (next_level) begin
          adv     = 1'b1;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (valid_q && char_ready) begin
          if (last_char) begin
            valid_d = 1'b0;
            wd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_q + CIDX_W'(1);
            data_d = tbl_q[level_q][idx_q + CIDX_W'(1)];
          end
        end
      end
      default: ;
    endcase
    if (adv) begin
      if (level_q == WIDX_W'(NUM_WORDS - 1)) begin
        if (WRAP) begin
          level_d = '0;
        end else begin
          gd_d    = 1'b1;
          state_d = S_DONE;
        end
      end else begin
        level_d = level_q + WIDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      wd_q    <= 1'b0;
      gd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      wd_q    <= wd_d;
      gd_q    <= gd_d;
    end
  end

  assign char_valid = valid_q;
  assign char_data  = data_q;
  assign char_idx   = idx_q;
  assign num_char   = num_q;
  assign level      = level_q;
  assign word_done  = wd_q;
  assign game_done  = gd_q;
  assign dbg_state  = state_q;

endmodule
